// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD CMD-line PHY.
// Optional receive CRC check: define SD_CMD_CRC_CHECK_EN.
package sd_cmd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_START,
    ST_RECEIVE,
    ST_DONE,
    ST_WAIT_ACK
  } state_t;

  localparam logic [1:0] RSP_NONE  = 2'b00;
  localparam logic [1:0] RSP_SHORT = 2'b01;
  localparam logic [1:0] RSP_LONG  = 2'b10;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_TIMEOUT = 2'b01;
  localparam logic [1:0] STAT_CRC     = 2'b10;

  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int         PAY_W     = 128;

  function automatic logic [6:0] crc7_step(
    input logic [6:0] c,
    input logic       d
  );
    logic fb;
    fb = c[6] ^ d;
    return {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_phy_if.sv
// Host-side command/result bundle of the SD CMD-line PHY.
// master = command controller, slave = PHY.
interface sd_cmd_phy_if #(
  parameter int CMD_W = 40
);
  logic             strobe_in;
  logic             ack_in;
  logic             idle_in;
  logic [CMD_W-1:0] cmd_to_send;
  logic [1:0]       rsp_type;
  logic             strobe_out;
  logic             ack_out;
  logic [127:0]     response;
  logic [1:0]       rsp_status;

  modport master (
    output strobe_in, ack_in, idle_in,
    output cmd_to_send, rsp_type,
    input  strobe_out, ack_out,
    input  response, rsp_status
  );

  modport slave (
    input  strobe_in, ack_in, idle_in,
    input  cmd_to_send, rsp_type,
    output strobe_out, ack_out,
    output response, rsp_status
  );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1); clear may coincide with the first data bit.
// Shared by the transmit and receive paths of sd_cmd_phy.
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d, seed;

  always_comb begin
    seed  = clr_i ? 7'd0 : crc_q;
    crc_d = seed;
    if (en_i) crc_d = crc7_step(seed, din_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_phy.sv
// SD CMD-line PHY: command serialiser with CRC7, response receiver.
// Define SD_CMD_CRC_CHECK_EN to check received CRC7 and end bit.
module sd_cmd_phy
  import sd_cmd_pkg::*;
#(
  parameter int CMD_W   = 40,
  parameter int SHORT_W = 48,
  parameter int LONG_W  = 136,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic         sd_clock,
  input  logic         reset,
  sd_cmd_phy_if.slave  host,
  output logic         cmd_out,
  output logic         cmd_oe,
  input  logic         cmd_in
);

  localparam logic [CNT_W-1:0] C_CMD   = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0] C_TX    = CNT_W'(CMD_W + 8);
  localparam logic [CNT_W-1:0] C_SLAST = CNT_W'(SHORT_W - 1);
  localparam logic [CNT_W-1:0] C_LLAST = CNT_W'(LONG_W - 1);
  localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(LONG_W);
  localparam logic [CNT_W-1:0] C_TMO   = CNT_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CMD_W-1:0]   sh_q, sh_d;
  logic [1:0]         rsp_q, rsp_d;
  logic [PAY_W-2:0]   frame_q, frame_d;
  logic [PAY_W-1:0]   rx_word;
  logic [PAY_W-1:0]   response_q, response_d;
  logic [1:0]         status_q, status_d;
  logic               oe_q, oe_d;
  logic               out_q, out_d;
  logic               tx_clr, tx_en, tx_din;
  logic [6:0]         tx_crc;
  logic               rsp_long;
  logic               rx_bad;

  assign rsp_long = (rsp_q == RSP_LONG);
  assign rx_word  = {frame_q, cmd_in};
  assign cnt_inc  = (cnt_q == C_LONG) ? cnt_q : cnt_q + 1'b1;

  sd_crc7 u_tx_crc (
    .clk_i (sd_clock),
    .rst_i (reset),
    .clr_i (tx_clr),
    .en_i  (tx_en),
    .din_i (tx_din),
    .crc_o (tx_crc)
  );

`ifdef SD_CMD_CRC_CHECK_EN
  localparam logic [CNT_W-1:0] C_SDAT = CNT_W'(SHORT_W - 8);
  localparam logic [CNT_W-1:0] C_HDR  = CNT_W'(LONG_W - PAY_W);
  localparam logic [CNT_W-1:0] C_PAY  = CNT_W'(PAY_W);

  logic       rx_clr, rx_en;
  logic [6:0] rx_crc;

  // The long-frame header is excluded from the receive CRC
  assign rx_clr = (state_q == ST_WAIT_START) && !cmd_in;
  assign rx_en  = rx_clr ? !rsp_long :
                  (state_q == ST_RECEIVE) &&
                  (rsp_long ? (cnt_q >= C_HDR && cnt_q < C_PAY)
                            : (cnt_q < C_SDAT));

  sd_crc7 u_rx_crc (
    .clk_i (sd_clock),
    .rst_i (reset),
    .clr_i (rx_clr),
    .en_i  (rx_en),
    .din_i (cmd_in),
    .crc_o (rx_crc)
  );

  assign rx_bad = (rx_crc != rx_word[7:1]) || !rx_word[0];
`else
  assign rx_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rsp_d      = rsp_q;
    frame_d    = frame_q;
    response_d = response_q;
    status_d   = status_q;
    oe_d       = oe_q;
    out_d      = out_q;
    tx_clr     = 1'b0;
    tx_en      = 1'b0;
    tx_din     = sh_q[CMD_W-1];

    unique case (state_q)
      ST_IDLE: begin
        oe_d  = 1'b1;
        out_d = 1'b1;
        cnt_d = '0;
        if (host.strobe_in) begin
          state_d = ST_SEND;
          rsp_d   = host.rsp_type;
          sh_d    = {host.cmd_to_send[CMD_W-2:0], 1'b0};
          out_d   = host.cmd_to_send[CMD_W-1];
          cnt_d   = CNT_W'(1);
          tx_clr  = 1'b1;
          tx_en   = 1'b1;
          tx_din  = host.cmd_to_send[CMD_W-1];
        end
      end

      ST_SEND: begin
        cnt_d = cnt_inc;
        sh_d  = {sh_q[CMD_W-2:0], 1'b0};
        out_d = sh_q[CMD_W-1];
        if (cnt_q < C_CMD) begin
          tx_en = 1'b1;
        end else if (cnt_q == C_CMD) begin
          // CRC is complete; reuse the shifter for crc[5:0] and end bit
          out_d = tx_crc[6];
          sh_d  = {tx_crc[5:0], 1'b1, {(CMD_W-7){1'b0}}};
        end else if (cnt_q == C_TX) begin
          oe_d  = 1'b0;
          out_d = 1'b1;
          cnt_d = '0;
          unique case (1'b1)
            (rsp_q == RSP_SHORT),
            (rsp_q == RSP_LONG): state_d = ST_WAIT_START;
            default: begin
              state_d  = ST_DONE;
              status_d = STAT_OK;
            end
          endcase
        end
      end

      ST_WAIT_START: begin
        cnt_d = cnt_inc;
        if (!cmd_in) begin
          state_d = ST_RECEIVE;
          frame_d = '0;
          cnt_d   = CNT_W'(1);
        end else if (cnt_inc == C_TMO) begin
          state_d    = ST_DONE;
          status_d   = STAT_TIMEOUT;
          response_d = '0;
        end
      end

      ST_RECEIVE: begin
        cnt_d   = cnt_inc;
        frame_d = rx_word[PAY_W-2:0];
        if (cnt_q == (rsp_long ? C_LLAST : C_SLAST)) begin
          state_d    = ST_DONE;
          status_d   = rx_bad ? STAT_CRC : STAT_OK;
          response_d = rsp_long ? rx_word
                                : PAY_W'(rx_word[SHORT_W-1:8]);
        end
      end

      ST_DONE: state_d = ST_WAIT_ACK;

      ST_WAIT_ACK: begin
        if (host.ack_in) begin
          state_d = ST_IDLE;
          oe_d    = 1'b1;
          out_d   = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (host.idle_in) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      oe_d       = 1'b1;
      out_d      = 1'b1;
      response_d = response_q;
      status_d   = status_q;
    end
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      rsp_q      <= RSP_NONE;
      frame_q    <= '0;
      response_q <= '0;
      status_q   <= STAT_OK;
      oe_q       <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rsp_q      <= rsp_d;
      frame_q    <= frame_d;
      response_q <= response_d;
      status_q   <= status_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
    end
  end

  assign cmd_out         = out_q;
  assign cmd_oe          = oe_q;
  assign host.strobe_out = (state_q == ST_DONE) && !host.idle_in;
  assign host.ack_out    = (state_q == ST_WAIT_ACK) && host.ack_in;
  assign host.response   = response_q;
  assign host.rsp_status = status_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Directed bench for sd_cmd_phy: framing, CRC, timeout, long rsp, abort.
// Honours SD_CMD_CRC_CHECK_EN for the corrupted-response case.
module tb_sd_cmd_phy;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_out, cmd_oe;
  logic cmd_in = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] last_resp;
  logic [1:0]   last_stat;

  sd_cmd_phy_if #(.CMD_W(40)) hif ();

  sd_cmd_phy dut (
    .sd_clock (clk),
    .reset    (rst),
    .host     (hif),
    .cmd_out  (cmd_out),
    .cmd_oe   (cmd_oe),
    .cmd_in   (cmd_in)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] crc7_ref(input logic [119:0] d);
    logic [6:0] r;
    logic       b;
    r = 7'd0;
    for (int i = 119; i >= 0; i--) begin
      b = d[i] ^ r[6];
      r = {r[5:0], 1'b0};
      if (b) r = r ^ 7'h09;
    end
    return r;
  endfunction

  // Issue a command, optionally play a response frame starting at
  // negedge 'start' (strobe sampled at cycle 0), then ack the result.
  task automatic run_cmd(
    input  logic [39:0]  cmd,
    input  logic [1:0]   rtype,
    input  logic [135:0] rsp,
    input  int           len,
    input  int           start,
    output logic [47:0]  tx,
    output int           cyc,
    output logic [127:0] resp,
    output logic [1:0]   stat,
    output logic         pulse_ok,
    output logic         ack_ok
  );
    logic a0, a1;
    tx  = '0;
    cyc = -1;
    @(negedge clk);
    hif.cmd_to_send = cmd;
    hif.rsp_type    = rtype;
    hif.strobe_in   = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      hif.strobe_in = 1'b0;
      if (c <= 48) tx = {tx[46:0], cmd_out};
      if (hif.strobe_out) begin
        cyc  = c;
        resp = hif.response;
        stat = hif.rsp_status;
        break;
      end
      if (len > 0 && c >= start && c < start + len)
        cmd_in = rsp[len-1-(c-start)];
      else
        cmd_in = 1'b1;
    end
    cmd_in = 1'b1;
    @(negedge clk);
    pulse_ok = !hif.strobe_out;
    a0 = hif.ack_out;
    hif.ack_in = 1'b1;
    #1 a1 = hif.ack_out;
    @(negedge clk);
    hif.ack_in = 1'b0;
    ack_ok = !a0 && a1 && cmd_oe && cmd_out;
    last_resp = hif.response;
    last_stat = hif.rsp_status;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({cmd_out, cmd_oe, hif.strobe_out, hif.ack_out} !== 4'b0 ||
        hif.response !== 128'd0 || hif.rsp_status !== 2'b00) begin
      n_err++;
      $display("FAIL reset_outputs: got out=%b oe=%b so=%b ao=%b rsp=%h st=%b, want all 0",
               cmd_out, cmd_oe, hif.strobe_out, hif.ack_out,
               hif.response, hif.rsp_status);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cmd_oe, cmd_out} !== 2'b11) begin
      n_err++;
      $display("FAIL idle_line: got oe,out=%b want 11", {cmd_oe, cmd_out});
    end
  endtask

  task automatic test_cmd0();
    logic [47:0] tx; int cyc; logic [127:0] r; logic [1:0] s;
    logic p, a;
    run_cmd(40'h40_0000_0000, 2'b00, '0, 0, 0, tx, cyc, r, s, p, a);
    n_cmp++;
    if (tx !== 48'h40_0000_0000_95) begin
      n_err++;
      $display("FAIL cmd0_frame: got %h want 400000000095", tx);
    end
    n_cmp++;
    if (cyc !== 49) begin
      n_err++;
      $display("FAIL cmd0_latency: got %0d want 49", cyc);
    end
    n_cmp++;
    if (s !== 2'b00 || p !== 1'b1) begin
      n_err++;
      $display("FAIL cmd0_status: got st=%b pulse_ok=%b want 00/1", s, p);
    end
  endtask

  task automatic test_short();
    logic [47:0] tx; int cyc; logic [127:0] r; logic [1:0] s;
    logic p, a;
    run_cmd(40'h48_0000_01AA, 2'b01, 136'(48'h08_0000_01AA_13),
            48, 53, tx, cyc, r, s, p, a);
    n_cmp++;
    if (tx !== 48'h48_0000_01AA_87) begin
      n_err++;
      $display("FAIL cmd8_frame: got %h want 48000001aa87", tx);
    end
    n_cmp++;
    if (r !== 128'h08_0000_01AA || s !== 2'b00) begin
      n_err++;
      $display("FAIL cmd8_resp: got %h st=%b want 08000001aa/00", r, s);
    end
    n_cmp++;
    if (cyc !== 101) begin
      n_err++;
      $display("FAIL cmd8_latency: got %0d want 101", cyc);
    end
  endtask

  task automatic test_timeout();
    logic [47:0] tx; int cyc; logic [127:0] r; logic [1:0] s;
    logic p, a;
    run_cmd(40'h48_0000_01AA, 2'b01, '0, 0, 0, tx, cyc, r, s, p, a);
    n_cmp++;
    if (cyc !== 113) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d want 113", cyc);
    end
    n_cmp++;
    if (s !== 2'b01 || r !== 128'd0) begin
      n_err++;
      $display("FAIL timeout_status: got st=%b rsp=%h want 01/0", s, r);
    end
  endtask

  task automatic test_crc_err();
    logic [47:0] tx; int cyc; logic [127:0] r; logic [1:0] s;
    logic p, a; logic [1:0] exp_s;
`ifdef SD_CMD_CRC_CHECK_EN
    exp_s = 2'b10;
`else
    exp_s = 2'b00;
`endif
    run_cmd(40'h48_0000_01AA, 2'b01, 136'(48'h08_0000_01A8_13),
            48, 53, tx, cyc, r, s, p, a);
    n_cmp++;
    if (s !== exp_s) begin
      n_err++;
      $display("FAIL crc_err_status: got %b want %b", s, exp_s);
    end
    n_cmp++;
    if (r !== 128'h08_0000_01A8) begin
      n_err++;
      $display("FAIL crc_err_resp: got %h want 08000001a8", r);
    end
  endtask

  task automatic test_long();
    logic [47:0] tx; int cyc; logic [127:0] r; logic [1:0] s;
    logic p, a;
    logic [119:0] cid;
    logic [135:0] fr;
    cid = 120'h0353_4453_4431_3647_8012_3456_7890_AB;
    fr  = {8'h3F, cid, crc7_ref(cid), 1'b1};
    run_cmd(40'h42_0000_0000, 2'b10, fr, 136, 53, tx, cyc, r, s, p, a);
    n_cmp++;
    if (r !== fr[127:0] || s !== 2'b00) begin
      n_err++;
      $display("FAIL long_resp: got %h st=%b want %h/00", r, s, fr[127:0]);
    end
    n_cmp++;
    if (cyc !== 189) begin
      n_err++;
      $display("FAIL long_latency: got %0d want 189", cyc);
    end
    n_cmp++;
    if (a !== 1'b1 || p !== 1'b1) begin
      n_err++;
      $display("FAIL long_ack: got ack_ok=%b pulse_ok=%b want 1/1", a, p);
    end
  endtask

  task automatic test_abort();
    logic [47:0] tx; int cyc; logic [127:0] r; logic [1:0] s;
    logic p, a;
    logic [127:0] keep_r;
    logic [1:0]   keep_s;
    int strobes;
    keep_r = last_resp;
    keep_s = last_stat;
    @(negedge clk);
    hif.cmd_to_send = 40'h51_0000_0000;
    hif.rsp_type    = 2'b01;
    hif.strobe_in   = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      hif.strobe_in = 1'b0;
      if (k == 21) hif.idle_in = 1'b1;
    end
    @(negedge clk);
    hif.idle_in = 1'b0;
    n_cmp++;
    if ({cmd_oe, cmd_out} !== 2'b11) begin
      n_err++;
      $display("FAIL abort_line: got oe,out=%b want 11", {cmd_oe, cmd_out});
    end
    strobes = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (hif.strobe_out || !cmd_oe) strobes++;
    end
    n_cmp++;
    if (strobes !== 0) begin
      n_err++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", strobes);
    end
    n_cmp++;
    if (hif.response !== keep_r || hif.rsp_status !== keep_s) begin
      n_err++;
      $display("FAIL abort_hold: got %h/%b want %h/%b",
               hif.response, hif.rsp_status, keep_r, keep_s);
    end
    run_cmd(40'h40_0000_0000, 2'b00, '0, 0, 0, tx, cyc, r, s, p, a);
    n_cmp++;
    if (tx !== 48'h40_0000_0000_95 || cyc !== 49 || s !== 2'b00) begin
      n_err++;
      $display("FAIL abort_resume: got %h cyc=%0d st=%b want 400000000095/49/00",
               tx, cyc, s);
    end
  endtask

  task automatic test_boundary();
    logic [47:0] tx; int cyc; logic [127:0] r; logic [1:0] s;
    logic p, a;
    run_cmd(40'h48_0000_01AA, 2'b01, 136'(48'h08_0000_01AA_13),
            48, 112, tx, cyc, r, s, p, a);
    n_cmp++;
    if (cyc !== 160 || s !== 2'b00 || r !== 128'h08_0000_01AA) begin
      n_err++;
      $display("FAIL start_at_limit: got cyc=%0d st=%b rsp=%h want 160/00/08000001aa",
               cyc, s, r);
    end
    run_cmd(40'h48_0000_01AA, 2'b01, 136'(48'h08_0000_01AA_13),
            48, 113, tx, cyc, r, s, p, a);
    n_cmp++;
    if (cyc !== 113 || s !== 2'b01) begin
      n_err++;
      $display("FAIL start_past_limit: got cyc=%0d st=%b want 113/01", cyc, s);
    end
  endtask

  task automatic test_reserved();
    logic [47:0] tx; int cyc; logic [127:0] r; logic [1:0] s;
    logic p, a;
    run_cmd(40'h40_0000_0000, 2'b11, '0, 0, 0, tx, cyc, r, s, p, a);
    n_cmp++;
    if (cyc !== 49 || s !== 2'b00) begin
      n_err++;
      $display("FAIL reserved_type: got cyc=%0d st=%b want 49/00", cyc, s);
    end
  endtask

  initial begin
    hif.strobe_in   = 1'b0;
    hif.ack_in      = 1'b0;
    hif.idle_in     = 1'b0;
    hif.cmd_to_send = '0;
    hif.rsp_type    = 2'b00;
    last_resp       = '0;
    last_stat       = '0;
    test_reset();
    test_cmd0();
    test_short();
    test_timeout();
    test_crc_err();
    test_long();
    test_abort();
    test_boundary();
    test_reserved();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
